mimo_ofdm_tx_cp_insert: RTL and testbench
=========================================

// Module: mimo_ofdm_tx_cp_insert
// PURPOSE
//  Transmit-side cyclic-prefix inserter for the 2x2 MIMO-OFDM link. Accepts 64 time-domain
//  IFFT samples per symbol for both TX streams and emits CP (last NCP samples) + NFFT body
//  per symbol to DAC1/DAC2, producing the 80-sample CP+data frame the receiver sync expects.
//  Ping-pong buffered so symbols stream back-to-back.
// PARAMETERS
//  DATA_W  16  signed width of each re/im component
//  NFFT    64  samples per symbol body (power of 2)
//  NCP     16  cyclic-prefix length (< NFFT)
// PORTS
//  clk       in   1       clock, all logic on rising edge
//  rst_n     in   1       synchronous active-low reset
//  in_valid  in   1       input sample valid
//  in_ready  out  1       block can accept a sample this cycle
//  in1_re    in   DATA_W  stream-1 IFFT sample, real
//  in1_im    in   DATA_W  stream-1 IFFT sample, imag
//  in2_re    in   DATA_W  stream-2 IFFT sample, real
//  in2_im    in   DATA_W  stream-2 IFFT sample, imag
//  out_valid out  1       DAC sample valid (no backpressure)
//  dac1_re   out  DATA_W  stream-1 output, real
//  dac1_im   out  DATA_W  stream-1 output, imag
//  dac2_re   out  DATA_W  stream-2 output, real
//  dac2_im   out  DATA_W  stream-2 output, imag
//  out_sof   out  1       high on first CP sample of each symbol
//  out_cp    out  1       high during the NCP prefix samples
//  underrun  out  1       1-cycle pulse: symbol ended, next bank not ready
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): full[1:0]=0, wr_bank=rd_bank=0, wr_idx=rd_idx=0, FSM=IDLE;
//   all outputs 0 (in_ready forced 0 while rst_n low). Buffer contents not cleared, never re-read.
//  Storage: 2 banks x NFFT words, word = {in1_re,in1_im,in2_re,in2_im}; data passes bit-exact.
//  Write side: in_ready = ~full[wr_bank]. Accept when in_valid&&in_ready: mem[wr_bank][wr_idx],
//   wr_idx++. Accept with wr_idx==NFFT-1: full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
//   in_valid while in_ready=0: sample ignored, no state change. Gaps in in_valid allowed.
//  Read FSM (uses registered full flags):
//   IDLE: full[rd_bank] -> CP, rd_idx<=NFFT-NCP.
//   CP:   emit mem[rd_bank][rd_idx], rd_idx++; at rd_idx==NFFT-1 -> BODY, rd_idx<=0.
//   BODY: emit mem[rd_bank][rd_idx], rd_idx++; at rd_idx==NFFT-1: full[rd_bank]<=0,
//         rd_bank toggles; if full[~rd_bank] already 1 -> CP (rd_idx<=NFFT-NCP), else IDLE
//         with underrun=1 for one cycle.
//  Output regs: synchronous read; out_valid/dac*/out_sof/out_cp lag the FSM state by 1 cycle.
//   Latency: first out_valid of a symbol 2 edges after the edge accepting its sample NFFT-1
//   (when FSM IDLE). dac* = 0 whenever out_valid=0. out_sof only with first CP sample.
//  Back-to-back: exactly NFFT+NCP contiguous valid cycles per symbol, no gap between symbols.
//  Simultaneous: write-completion setting full[x] and BODY end on the same edge -> flag not yet
//   seen: IDLE + underrun, CP starts next edge (1-cycle gap). Write and read never share a bank
//   (write blocked by full), so set/clear on one edge target different banks.
//  Throughput: NFFT inputs per NFFT+NCP output cycles; in_ready drops once both banks full.
//  Reset mid-operation: aborts instantly; partial symbol discarded, nothing from old banks emitted.
// TESTING
//  1 One symbol, sample k=(k,-k,1000+k,-1000-k), in_valid continuous -> in_ready stays 1; 80
//    valid outs: k=48..63 then 0..63; out_sof 1st cycle, out_cp 16 cycles; underrun pulse after.
//  2 Three symbols, in_valid always 1 -> 128 accepts then in_ready=0 until bank freed; 240
//    contiguous out_valid cycles, 3 out_sof pulses, underrun only after 3rd symbol.
//  3 in_valid every other cycle, same ramp -> output order/values identical to test 1.
//  4 rst_n low 1 cycle at output index 30 of symbol 1 -> next cycle all outputs 0; after release
//    in_ready=1, no out_valid until a fresh 64-sample symbol is accepted.
//  5 Samples -32768/32767 on all four lanes -> DAC values bit-exact, no sign corruption.
//  6 Symbol 2's last sample accepted on same edge symbol 1 BODY ends -> underrun=1, 1-cycle gap,
//    symbol 2 CP starts following cycle, 80 valid samples.

Source files
------------

// File: rtl/mimo_ofdm_tx_cp_insert.sv
// Cyclic-prefix inserter for the 2x2 MIMO-OFDM transmitter: ping-pong buffers one
// NFFT-sample symbol per bank and replays the last NCP samples ahead of the full body.
// state  | meaning
// IDLE   | waiting for the read bank to fill
// CP     | replaying prefix samples NFFT-NCP..NFFT-1
// BODY   | replaying body samples 0..NFFT-1
module mimo_ofdm_tx_cp_insert #(
    parameter int DATA_W = 16,
    parameter int NFFT   = 64,
    parameter int NCP    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in1_re,
    input  logic signed [DATA_W-1:0] in1_im,
    input  logic signed [DATA_W-1:0] in2_re,
    input  logic signed [DATA_W-1:0] in2_im,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] dac1_re,
    output logic signed [DATA_W-1:0] dac1_im,
    output logic signed [DATA_W-1:0] dac2_re,
    output logic signed [DATA_W-1:0] dac2_im,
    output logic                     out_sof,
    output logic                     out_cp,
    output logic                     underrun
);

    localparam int AW = $clog2(NFFT);
    localparam int WW = 4 * DATA_W;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CP   = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [AW-1:0] IDX_LAST = AW'(NFFT - 1);
    localparam logic [AW-1:0] IDX_CP   = AW'(NFFT - NCP);

    logic [WW-1:0] mem_q [2*NFFT];

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]    state_q, state_d;
    logic          underrun_q, underrun_d;
    logic          out_valid_q, out_sof_q, out_cp_q;
    logic [WW-1:0] out_data_q;
    logic          wr_en;

    assign in_ready = rst_n & ~full_q[wr_bank_q];
    assign wr_en    = in_valid & in_ready;

    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        wr_idx_d   = wr_idx_q;
        rd_bank_d  = rd_bank_q;
        rd_idx_d   = rd_idx_q;
        state_d    = state_q;
        underrun_d = 1'b0;

        if (wr_en) begin
            wr_idx_d = wr_idx_q + AW'(1);
            if (wr_idx_q == IDX_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
            end
        end

        // Read side only looks at registered flags; a bank completing on the same
        // edge a body ends is picked up one cycle later.
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = S_CP;
                    rd_idx_d = IDX_CP;
                end
            end
            S_CP: begin
                rd_idx_d = rd_idx_q + AW'(1);
                if (rd_idx_q == IDX_LAST) begin
                    state_d  = S_BODY;
                    rd_idx_d = '0;
                end
            end
            S_BODY: begin
                rd_idx_d = rd_idx_q + AW'(1);
                if (rd_idx_q == IDX_LAST) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    if (full_q[~rd_bank_q]) begin
                        state_d  = S_CP;
                        rd_idx_d = IDX_CP;
                    end else begin
                        state_d    = S_IDLE;
                        rd_idx_d   = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank_q, wr_idx_q}] <= {in1_re, in1_im, in2_re, in2_im};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            state_q     <= S_IDLE;
            underrun_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_cp_q    <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            state_q     <= state_d;
            underrun_q  <= underrun_d;
            out_valid_q <= (state_q != S_IDLE);
            out_sof_q   <= (state_q == S_CP) && (rd_idx_q == IDX_CP);
            out_cp_q    <= (state_q == S_CP);
            out_data_q  <= (state_q != S_IDLE) ? mem_q[{rd_bank_q, rd_idx_q}] : '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_cp    = out_cp_q;
    assign underrun  = underrun_q;
    assign dac1_re   = out_data_q[4*DATA_W-1 -: DATA_W];
    assign dac1_im   = out_data_q[3*DATA_W-1 -: DATA_W];
    assign dac2_re   = out_data_q[2*DATA_W-1 -: DATA_W];
    assign dac2_im   = out_data_q[DATA_W-1 -: DATA_W];

endmodule

// File: tb/tb_mimo_ofdm_tx_cp_insert.sv
// Bench for the CP inserter: a model builds the expected 80-sample frame whenever a
// symbol's 64th sample is accepted; a monitor pops and compares every DAC cycle.
module tb_mimo_ofdm_tx_cp_insert;

    localparam int DW   = 16;
    localparam int NFFT = 64;
    localparam int NCP  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in1_re, in1_im, in2_re, in2_im;
    logic          out_valid;
    logic [DW-1:0] dac1_re, dac1_im, dac2_re, dac2_im;
    logic          out_sof, out_cp, underrun;

    always #5 clk = ~clk;

    mimo_ofdm_tx_cp_insert #(.DATA_W(DW), .NFFT(NFFT), .NCP(NCP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1_re(in1_re), .in1_im(in1_im), .in2_re(in2_re), .in2_im(in2_im),
        .out_valid(out_valid), .dac1_re(dac1_re), .dac1_im(dac1_im),
        .dac2_re(dac2_re), .dac2_im(dac2_im), .out_sof(out_sof), .out_cp(out_cp),
        .underrun(underrun)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        sof;
        logic        cp;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] sym_buf [NFFT];
    int          wcnt;
    int          errors, checks;
    int          vcnt, sofcnt, cpcnt, runs, last_gap, idle_run;
    int          under_at[$];
    logic        prev_valid;

    function automatic logic [63:0] ramp(input int k);
        logic [15:0] a, b, c, d;
        a = 16'(k);
        b = 16'(-k);
        c = 16'(1000 + k);
        d = 16'(-1000 - k);
        return {a, b, c, d};
    endfunction

    task automatic clear_stats();
        vcnt = 0; sofcnt = 0; cpcnt = 0; runs = 0; last_gap = -1; idle_run = 0;
        under_at.delete();
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                vcnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 at t=%0t, required 0 (nothing pending)", $time);
                end else begin
                    e = sb_q.pop_front();
                    if ({dac1_re, dac1_im, dac2_re, dac2_im} !== e.d || out_sof !== e.sof || out_cp !== e.cp) begin
                        errors++;
                        $display("FAIL sb_sample: got d=%h sof=%b cp=%b required d=%h sof=%b cp=%b",
                                 {dac1_re, dac1_im, dac2_re, dac2_im}, out_sof, out_cp, e.d, e.sof, e.cp);
                    end
                end
                if (prev_valid !== 1'b1) begin
                    runs++;
                    last_gap = idle_run;
                end
                idle_run = 0;
            end else begin
                checks++;
                if ({out_valid, dac1_re, dac1_im, dac2_re, dac2_im, out_sof, out_cp} !== '0) begin
                    errors++;
                    $display("FAIL idle_zero: got valid=%b d=%h sof=%b cp=%b required all 0",
                             out_valid, {dac1_re, dac1_im, dac2_re, dac2_im}, out_sof, out_cp);
                end
                idle_run++;
            end
            if (out_sof === 1'b1) sofcnt++;
            if (out_cp === 1'b1) cpcnt++;
            if (underrun === 1'b1) under_at.push_back(vcnt);
            prev_valid = out_valid;
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, output logic acc);
        @(negedge clk);
        in_valid = v;
        {in1_re, in1_im, in2_re, in2_im} = d;
        acc = v && (in_ready === 1'b1);
        if (acc) begin
            sym_buf[wcnt] = d;
            wcnt++;
            if (wcnt == NFFT) begin
                for (int i = NFFT - NCP; i < NFFT; i++)
                    sb_q.push_back('{d: sym_buf[i], sof: (i == NFFT - NCP), cp: 1'b1});
                for (int i = 0; i < NFFT; i++)
                    sb_q.push_back('{d: sym_buf[i], sof: 1'b0, cp: 1'b0});
                wcnt = 0;
            end
        end
    endtask

    task automatic wait_drain(input int limit, output logic ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (sb_q.size() == 0 && out_valid !== 1'b1) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        {in1_re, in1_im, in2_re, in2_im} = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        checks++;
        if ({out_valid, dac1_re, dac1_im, dac2_re, dac2_im, out_sof, out_cp, underrun} !== '0) begin
            errors++;
            $display("FAIL rst_outputs: got valid=%b sof=%b cp=%b und=%b required all 0", out_valid, out_sof, out_cp, underrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_one_symbol();
        logic acc, ok;
        clear_stats();
        for (int k = 0; k < NFFT; k++) begin
            drive(1'b1, ramp(k), acc);
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL one_in_ready: sample %0d got ready=0 required 1", k); end
        end
        wait_drain(300, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL one_drain: got timeout required drained"); end
        checks++;
        if (vcnt !== 80 || sofcnt !== 1 || cpcnt !== 16 || runs !== 1) begin
            errors++;
            $display("FAIL one_counts: got valid=%0d sof=%0d cp=%0d runs=%0d required 80 1 16 1", vcnt, sofcnt, cpcnt, runs);
        end
        checks++;
        if (under_at.size() != 1 || under_at[0] != 80) begin
            errors++;
            $display("FAIL one_underrun: got %0d pulses (first at %0d) required 1 at 80", under_at.size(),
                     under_at.size() > 0 ? under_at[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, ok;
        int accepted, blocked_at, cyc;
        clear_stats();
        accepted = 0; blocked_at = -1; cyc = 0;
        while (accepted < 3 * NFFT && cyc < 2000) begin
            drive(1'b1, ramp((accepted % NFFT) + 300 * (accepted / NFFT)), acc);
            if (acc) accepted++;
            else if (blocked_at < 0) blocked_at = accepted;
            cyc++;
        end
        checks++;
        if (accepted !== 192 || blocked_at !== 128) begin
            errors++;
            $display("FAIL b2b_accepts: got accepted=%0d first_block_at=%0d required 192 128", accepted, blocked_at);
        end
        wait_drain(500, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL b2b_drain: got timeout required drained"); end
        checks++;
        if (vcnt !== 240 || sofcnt !== 3 || cpcnt !== 48 || runs !== 1) begin
            errors++;
            $display("FAIL b2b_counts: got valid=%0d sof=%0d cp=%0d runs=%0d required 240 3 48 1", vcnt, sofcnt, cpcnt, runs);
        end
        checks++;
        if (under_at.size() != 1 || under_at[0] != 240) begin
            errors++;
            $display("FAIL b2b_underrun: got %0d pulses required 1 at 240", under_at.size());
        end
    endtask

    task automatic test_gapped();
        logic acc, ok;
        clear_stats();
        for (int c = 0; c < 2 * NFFT; c++) begin
            drive((c % 2) == 0, ramp(c / 2), acc);
            if ((c % 2) == 0) begin
                checks++;
                if (acc !== 1'b1) begin errors++; $display("FAIL gap_in_ready: cycle %0d got 0 required 1", c); end
            end
        end
        wait_drain(300, ok);
        checks++;
        if (ok !== 1'b1 || vcnt !== 80 || sofcnt !== 1 || cpcnt !== 16) begin
            errors++;
            $display("FAIL gap_counts: got ok=%b valid=%0d sof=%0d cp=%0d required 1 80 1 16", ok, vcnt, sofcnt, cpcnt);
        end
    endtask

    task automatic test_extremes();
        logic acc, ok;
        logic [15:0] v;
        clear_stats();
        for (int k = 0; k < NFFT; k++) begin
            v = ((k % 3) == 0) ? 16'h8000 : 16'h7FFF;
            drive(1'b1, {v, ~v, ~v, v}, acc);
        end
        wait_drain(300, ok);
        checks++;
        if (ok !== 1'b1 || vcnt !== 80 || under_at.size() != 1) begin
            errors++;
            $display("FAIL ext_counts: got ok=%b valid=%0d underruns=%0d required 1 80 1", ok, vcnt, under_at.size());
        end
    endtask

    task automatic test_simultaneous();
        logic acc, ok;
        int nacc;
        clear_stats();
        nacc = 0;
        for (int k = 0; k < NFFT; k++) begin drive(1'b1, ramp(k + 500), acc); if (acc) nacc++; end
        for (int k = 0; k < 17; k++) drive(1'b0, '0, acc);
        for (int k = 0; k < NFFT; k++) begin drive(1'b1, ramp(k + 2000), acc); if (acc) nacc++; end
        wait_drain(400, ok);
        checks++;
        if (ok !== 1'b1 || nacc !== 128) begin errors++; $display("FAIL sim_accepts: got ok=%b acc=%0d required 1 128", ok, nacc); end
        checks++;
        if (vcnt !== 160 || sofcnt !== 2 || runs !== 2 || last_gap !== 1) begin
            errors++;
            $display("FAIL sim_counts: got valid=%0d sof=%0d runs=%0d gap=%0d required 160 2 2 1", vcnt, sofcnt, runs, last_gap);
        end
        checks++;
        if (under_at.size() != 2 || under_at[0] != 80 || under_at[1] != 160) begin
            errors++;
            $display("FAIL sim_underrun: got %0d pulses required 2 at 80,160", under_at.size());
        end
    endtask

    task automatic test_reset_mid();
        logic acc, ok;
        int cyc, k2;
        clear_stats();
        for (int k = 0; k < NFFT; k++) drive(1'b1, ramp(k + 50), acc);
        cyc = 0; k2 = 0;
        while (vcnt < 30 && cyc < 200) begin
            drive(1'b1, ramp(k2 + 900), acc);
            if (acc) k2++;
            cyc++;
        end
        checks++;
        if (vcnt < 30) begin errors++; $display("FAIL rmid_reach: got valid=%0d required >=30", vcnt); end
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        wcnt = 0;
        checks++;
        if ({out_valid, dac1_re, dac1_im, dac2_re, dac2_im, out_sof, out_cp, underrun, in_ready} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs: got valid=%b ready=%b sof=%b cp=%b required all 0", out_valid, in_ready, out_sof, out_cp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b required 1", in_ready); end
        clear_stats();
        for (int k = 0; k < 40; k++) drive(1'b0, '0, acc);
        checks++;
        if (vcnt !== 0) begin errors++; $display("FAIL rmid_stale: got valid=%0d required 0", vcnt); end
        for (int k = 0; k < NFFT; k++) drive(1'b1, ramp(k + 4000), acc);
        wait_drain(300, ok);
        checks++;
        if (ok !== 1'b1 || vcnt !== 80 || sofcnt !== 1 || under_at.size() != 1) begin
            errors++;
            $display("FAIL rmid_fresh: got ok=%b valid=%0d sof=%0d und=%0d required 1 80 1 1", ok, vcnt, sofcnt, under_at.size());
        end
    endtask

    initial begin
        errors = 0; checks = 0; wcnt = 0; prev_valid = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0;
        {in1_re, in1_im, in2_re, in2_im} = '0;
        clear_stats();
        fork
            monitor_loop();
            begin
                #500000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_one_symbol();
        test_back_to_back();
        test_gapped();
        test_extremes();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
